map_sst_seq: RTL
================

Name: map_sst_seq

Overview:
- Save-state sequencer for the VRC-family mapper register file (CHR/PRG banks, swap and mirroring registers, IRQ state).
- On command, it walks the mapper save-state register space over the sst bus (address, we_reg, dato, di). It streams each byte to or from a host state buffer through a req/ack memory port.
- It sits beside the mapper inside the mapper wrapper and replaces ad-hoc host-driven sst bus access.

Parameters:
- REG_CNT, 128: number of sst register addresses walked (0..REG_CNT-1). The last address holds the mapper-index signature.
- SIG_ADDR, REG_CNT-1: sst/buffer address of the map_idx signature byte.

Ports:
- m2  in  1  CPU M2 clock; all state updates on the falling edge of m2.
- map_rst_n  in  1  synchronous active-low reset, sampled on the falling edge of m2.
- cmd_save  in  1  one-cycle pulse; starts a snapshot.
- cmd_load  in  1  one-cycle pulse; starts a restore.
- cfg_map_idx  in  8  current mapper index, used for the signature check.
- busy  out  1  high while a sequence runs.
- done  out  1  one-cycle completion pulse.
- err  out  1  sticky signature-mismatch flag; cleared by the next command.
- sst_act  out  1  sst bus ownership; mapper registers are frozen to sst access while high.
- sst_addr  out  8  sst register address.
- sst_we_reg  out  1  one-cycle register write strobe.
- sst_dato  out  8  data written to the mapper.
- sst_di  in  8  mapper readback for sst_addr (combinational).
- mem_req  out  1  buffer access request.
- mem_we  out  1  1 = write buffer, 0 = read buffer.
- mem_addr  out  8  buffer byte address; always equals sst_addr.
- mem_wdat  out  8  buffer write data.
- mem_rdat  in  8  buffer read data; valid in the cycle mem_ack is high.
- mem_ack  in  1  completes the current request.

Behaviour:
- Reset (map_rst_n=0 at an m2 falling edge): state IDLE, every output 0, err 0.
  - Reset mid-sequence aborts immediately: sst_act drops in the same edge, no further sst_we_reg is issued.
  - Any partially restored registers keep their values.
- States:
  - IDLE: accept commands.
  - SV_RD: sst_act=1, sst_addr=a; one settle cycle for sst_di.
  - SV_WR: mem_req=1, mem_we=1, mem_wdat registered from sst_di at SV_RD exit; held until mem_ack.
  - LD_SIG: mem_req=1, mem_we=0, mem_addr=SIG_ADDR; held until mem_ack.
  - LD_RQ: mem_req=1, mem_we=0, mem_addr=a; held until mem_ack. mem_rdat is captured into sst_dato on ack.
  - LD_WR: sst_we_reg=1 for exactly one cycle with sst_addr=a.
  - FIN: done=1 for one cycle, then IDLE.
- Commands:
  - IDLE + cmd_save → SV_RD, a=0, err cleared.
  - IDLE + cmd_load → LD_SIG, err cleared.
  - cmd_save and cmd_load in the same cycle: save wins.
  - Commands while busy are ignored.
- Save transitions:
  - SV_WR + ack: if a==REG_CNT-1 → FIN, else a+1 → SV_RD.
  - All REG_CNT addresses, including the signature, are saved.
- Load transitions:
  - LD_SIG + ack: if mem_rdat != cfg_map_idx → err=1, FIN; no sst_we_reg is ever issued.
  - LD_SIG + ack with a match: a=0 → LD_RQ.
  - LD_WR: if a==REG_CNT-2 → FIN, else a+1 → LD_RQ. The signature address is never written.
- sst_act: high in every state except IDLE and FIN.
- busy: high in every state except IDLE. It falls the cycle after FIN.
- mem_ack: ignored unless mem_req is high. An ack in the first cycle of mem_req is legal (zero wait).
- Latency with zero-wait ack:
  - Save: 2*REG_CNT busy cycles before FIN (256 for the default).
  - Load: 1 + 2*(REG_CNT-1) cycles before FIN (255); a signature mismatch gives 1.
- Counter a is 8 bits. It never wraps: its terminal compares stop it at REG_CNT-1 (save) or REG_CNT-2 (load).
- mem_req, mem_we, mem_addr and mem_wdat are stable from request until ack inclusive.

Decomposition:
- Package map_sst_pkg holds:
  - sst_state_t enum {IDLE, SV_RD, SV_WR, LD_SIG, LD_RQ, LD_WR, FIN}
  - SST_REG_CNT = 128
  - SST_SIG_ADDR = 127
  - the sst address map constants: CHR low 0-7, CHR high 8-15, PRG 16-17, mode 18, IRQ 32-36, signature 127.
- Single module; no sub-module is natural.

Test Plan:
- Save, zero-wait ack: mapper loaded with chr_reg0=0x5A, prg_reg0=0x03, map_idx=21; pulse cmd_save → buffer[0]=0x5A, buffer[16]=0x03, buffer[127]=21; done exactly 256 cycles after start; 128 write acks total.
- Load round-trip: buffer[0..126] = incrementing pattern, buffer[127]=21, cfg_map_idx=21; pulse cmd_load → 127 sst_we_reg strobes at addresses 0..126, none at 127; readback of sst address 17 equals buffer[17]; err=0.
- Signature mismatch: buffer[127]=23, cfg_map_idx=21; pulse cmd_load → err=1, done after 1 ack, zero sst_we_reg strobes, mapper registers unchanged.
- Wait states: mem_ack delayed 3 cycles per request during save → request signals stable throughout; buffer content identical to the zero-wait case; done at 2*128+3*128 cycles.
- Simultaneous/ignored commands: cmd_save and cmd_load in the same cycle → save sequence runs; cmd_load pulsed mid-save → ignored; no LD_SIG request appears.
- Reset mid-load: map_rst_n=0 after 10 sst_we_reg strobes → next edge sst_act=0, busy=0, mem_req=0; registers 0..9 keep restored values, 10..126 unchanged.

Source files
------------

// File: rtl/map_sst_pkg.sv
// Shared types and sst address map for the mapper save-state sequencer.
// The address map is exported for the mapper wrapper and host tooling.
package map_sst_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SV_RD,
    SV_WR,
    LD_SIG,
    LD_RQ,
    LD_WR,
    FIN
  } sst_state_t;

  localparam int SST_REG_CNT  = 128;
  localparam int SST_SIG_ADDR = 127;

  // Mapper register placement inside the sst space
  localparam logic [7:0] SST_CHR_LO_BASE = 8'd0;
  localparam logic [7:0] SST_CHR_LO_LAST = 8'd7;
  localparam logic [7:0] SST_CHR_HI_BASE = 8'd8;
  localparam logic [7:0] SST_CHR_HI_LAST = 8'd15;
  localparam logic [7:0] SST_PRG_BASE    = 8'd16;
  localparam logic [7:0] SST_PRG_LAST    = 8'd17;
  localparam logic [7:0] SST_MODE_ADDR   = 8'd18;
  localparam logic [7:0] SST_IRQ_BASE    = 8'd32;
  localparam logic [7:0] SST_IRQ_LAST    = 8'd36;
  localparam logic [7:0] SST_SIG_BYTE    = 8'd127;

endpackage

// File: rtl/map_sst_seq.sv
// Save-state sequencer: walks the mapper sst register space and streams each
// byte to (save) or from (load) a host buffer over a req/ack memory port.
module map_sst_seq
  import map_sst_pkg::*;
#(
  parameter int REG_CNT  = SST_REG_CNT,
  parameter int SIG_ADDR = REG_CNT - 1
) (
  input  logic       m2,
  input  logic       map_rst_n,
  input  logic       cmd_save,
  input  logic       cmd_load,
  input  logic [7:0] cfg_map_idx,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       sst_act,
  output logic [7:0] sst_addr,
  output logic       sst_we_reg,
  output logic [7:0] sst_dato,
  input  logic [7:0] sst_di,
  output logic       mem_req,
  output logic       mem_we,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdat,
  input  logic [7:0] mem_rdat,
  input  logic       mem_ack
);

  localparam logic [7:0] SAVE_LAST = 8'(REG_CNT - 1);
  localparam logic [7:0] LOAD_LAST = 8'(REG_CNT - 2);
  localparam logic [7:0] SIG       = 8'(SIG_ADDR);

  sst_state_t state_reg, state_next;
  logic [7:0] a_reg, a_next;
  logic [7:0] wdat_reg, wdat_next;
  logic [7:0] dato_reg, dato_next;
  logic       err_reg, err_next;

  // The mapper runs on the M2 falling edge, so the sequencer does too.
  always_ff @(negedge m2) begin
    if (!map_rst_n) begin
      state_reg <= IDLE;
      a_reg     <= 8'd0;
      wdat_reg  <= 8'd0;
      dato_reg  <= 8'd0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      a_reg     <= a_next;
      wdat_reg  <= wdat_next;
      dato_reg  <= dato_next;
      err_reg   <= err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    a_next     = a_reg;
    wdat_next  = wdat_reg;
    dato_next  = dato_reg;
    err_next   = err_reg;
    case (state_reg)
      IDLE: begin
        if (cmd_save) begin
          state_next = SV_RD;
          a_next     = 8'd0;
          err_next   = 1'b0;
        end else if (cmd_load) begin
          state_next = LD_SIG;
          err_next   = 1'b0;
        end
      end
      SV_RD: begin
        // sst_di has settled for a full cycle; freeze it for the request.
        wdat_next  = sst_di;
        state_next = SV_WR;
      end
      SV_WR: begin
        if (mem_ack) begin
          if (a_reg == SAVE_LAST) begin
            state_next = FIN;
          end else begin
            a_next     = a_reg + 8'd1;
            state_next = SV_RD;
          end
        end
      end
      LD_SIG: begin
        if (mem_ack) begin
          if (mem_rdat != cfg_map_idx) begin
            err_next   = 1'b1;
            state_next = FIN;
          end else begin
            a_next     = 8'd0;
            state_next = LD_RQ;
          end
        end
      end
      LD_RQ: begin
        if (mem_ack) begin
          dato_next  = mem_rdat;
          state_next = LD_WR;
        end
      end
      LD_WR: begin
        // Stopping one short of the end keeps the signature byte untouched.
        if (a_reg == LOAD_LAST) begin
          state_next = FIN;
        end else begin
          a_next     = a_reg + 8'd1;
          state_next = LD_RQ;
        end
      end
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  logic [7:0] addr_mux;

  always_comb begin
    busy       = (state_reg != IDLE);
    done       = (state_reg == FIN);
    sst_act    = (state_reg != IDLE) && (state_reg != FIN);
    sst_we_reg = (state_reg == LD_WR);
    mem_req    = (state_reg == SV_WR) || (state_reg == LD_SIG) || (state_reg == LD_RQ);
    mem_we     = (state_reg == SV_WR);
    addr_mux   = 8'd0;
    if (state_reg == LD_SIG) begin
      addr_mux = SIG;
    end else if (sst_act) begin
      addr_mux = a_reg;
    end
  end

  assign sst_addr = addr_mux;
  assign mem_addr = addr_mux;
  assign sst_dato = dato_reg;
  assign mem_wdat = wdat_reg;
  assign err      = err_reg;

endmodule
